mult_seq_param: RTL and testbench
=================================

MULT_SEQ_PARAM -- requirements
Module: mult_seq_param

Interface
REQ-001 Parameter WIDTH, default 4: operand and truncated-result width; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low; sampled on rising clk edge.
REQ-004 start  input  1  request pulse; accepted only in IDLE.
REQ-005 sgn  input  1  mode select, sampled with start: 0 = unsigned, 1 = two's-complement.
REQ-006 x  input  WIDTH  multiplicand, sampled with start.
REQ-007 y  input  WIDTH  multiplier, sampled with start.
REQ-008 busy  output  1  high while a multiplication is in progress.
REQ-009 done  output  1  one-cycle pulse when res, prod and ovf become valid.
REQ-010 prod  output  2*WIDTH  full product.
REQ-011 res  output  WIDTH  low WIDTH bits of prod.
REQ-012 ovf  output  1  high when the full product is not representable in WIDTH bits in the selected mode.

Function
REQ-013 The FSM shall have states IDLE, CALC and FIX; all other encodings shall return to IDLE on the next edge.
REQ-014 IDLE with start=1 shall capture x, y and sgn, clear the accumulator, load the step counter with WIDTH, and enter CALC with busy=1 on the next cycle.
REQ-015 In sgn=1, operands shall be captured as magnitudes, and the result sign (x[MSB] XOR y[MSB]) shall be stored at capture.
REQ-016 CALC shall perform one shift-add step per cycle (LSB of multiplier selects add of multiplicand) and decrement the counter.
REQ-017 CALC shall last exactly WIDTH cycles, then enter FIX.
REQ-018 FIX shall negate the magnitude product when the stored sign is 1, drive prod, res and ovf, pulse done for one cycle, drop busy, and return to IDLE.
REQ-019 Latency from the start-accept edge to the done pulse shall be WIDTH+2 cycles, independent of operand values.
REQ-020 Unsigned ovf shall be 1 iff prod[2*WIDTH-1:WIDTH] != 0.
REQ-021 Signed ovf shall be 1 iff prod[2*WIDTH-1:WIDTH-1] is neither all-zeros nor all-ones.
REQ-022 Signed -2^(WIDTH-1) operands shall be handled correctly; magnitude registers shall be WIDTH bits unsigned so 2^(WIDTH-1) is representable.
REQ-023 start while busy=1 shall be ignored, with no effect on the running operation and no queueing.
REQ-024 Changes to x, y and sgn after capture shall not affect the running operation.
REQ-025 prod, res and ovf shall hold their last values until the next done pulse.
REQ-026 start asserted in the same cycle as done shall not be accepted; a new start is accepted from the following IDLE cycle.
REQ-027 A zero operand shall not shorten latency; the result shall be prod=0 and ovf=0.

Reset
REQ-028 rst_n=0 on a rising edge shall force IDLE, busy=0, done=0, prod=0, res=0, ovf=0, and clear the counter and working registers.
REQ-029 Reset during CALC or FIX shall abort the operation without a done pulse.
REQ-030 start asserted together with rst_n=0 shall be ignored.

Structure
REQ-031 A shared package mult_pkg shall hold the state enum (IDLE, CALC, FIX) and the WIDTH default constant.
REQ-032 A single sub-module mult_sign_fix shall hold the combinational magnitude/negate and ovf logic, instantiated once.
REQ-033 The datapath shall use one adder of WIDTH+1 bits; no array multiplier is permitted.

Verification
REQ-034 WIDTH=4, sgn=0, x=3, y=5 -> done 6 cycles after accept; prod=15, res=15, ovf=0.
REQ-035 WIDTH=4, sgn=0, x=15, y=15 -> prod=225 (0xE1), res=1, ovf=1.
REQ-036 WIDTH=4, sgn=1, x=-8, y=-1 -> prod=8 (0x08), res=8 (reads as -8), ovf=1; with x=-2, y=3 -> prod=0xFA, res=0xA, ovf=0.
REQ-037 Issue start mid-CALC with different operands -> ignored; the original result is delivered and only one done pulse occurs.
REQ-038 Deassert rst_n in CALC cycle 2 -> next cycle IDLE, busy=0, outputs 0, no done; a fresh start then completes normally.
REQ-039 Exhaustive WIDTH=4 sweep in both modes -> prod matches the reference product and ovf matches REQ-020/021 for all 512 cases.

Source files
------------

// File: rtl/mult_seq_param_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
package mult_pkg;

  localparam int WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/mult_seq_param_if.sv
// Request/result bundle between a multiplier client and mult_seq_param.
interface mult_seq_param_if
  import mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);
  logic               start;
  logic               sgn;
  logic [WIDTH-1:0]   x;
  logic [WIDTH-1:0]   y;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   res;
  logic               ovf;

  modport master (
    output start, sgn, x, y,
    input  busy, done, prod, res, ovf
  );

  modport slave (
    input  start, sgn, x, y,
    output busy, done, prod, res, ovf
  );
endinterface

// File: rtl/mult_seq_param_sign_fix.sv
// Combinational sign handling: operand magnitudes at capture, product
// negation and overflow detection at the end of the run.
module mult_sign_fix
  import mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               i_sgn,
  input  logic [WIDTH-1:0]   i_x,
  input  logic [WIDTH-1:0]   i_y,
  input  logic               i_sgn_q,
  input  logic               i_neg_q,
  input  logic [2*WIDTH-1:0] i_mag,
  output logic [WIDTH-1:0]   o_x_mag,
  output logic [WIDTH-1:0]   o_y_mag,
  output logic               o_neg,
  output logic [2*WIDTH-1:0] o_prod,
  output logic               o_ovf
);

  logic [WIDTH:0] w_top;

  // Magnitude of -2^(WIDTH-1) wraps to 2^(WIDTH-1), which fits as unsigned.
  assign o_x_mag = (i_sgn && i_x[WIDTH-1]) ? (~i_x + WIDTH'(1)) : i_x;
  assign o_y_mag = (i_sgn && i_y[WIDTH-1]) ? (~i_y + WIDTH'(1)) : i_y;
  assign o_neg   = i_sgn & (i_x[WIDTH-1] ^ i_y[WIDTH-1]);

  assign o_prod  = i_neg_q ? (~i_mag + (2*WIDTH)'(1)) : i_mag;
  assign w_top   = o_prod[2*WIDTH-1:WIDTH-1];

  // Signed fits iff the upper half plus the result sign bit are all equal.
  assign o_ovf   = i_sgn_q ? !((&w_top) || !(|w_top))
                           : (|o_prod[2*WIDTH-1:WIDTH]);

endmodule

// File: rtl/mult_seq_param.sv
// Sequential shift-add multiplier: one add step per cycle over WIDTH cycles,
// then a sign-fix cycle that publishes prod/res/ovf with a done pulse.
module mult_seq_param
  import mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input logic             clk,
  input logic             rst_n,
  mult_seq_param_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t             r_state;
  state_t             w_next;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic               r_sgn;
  logic               r_neg;
  logic               r_done;
  logic               r_ovf;
  logic [2*WIDTH-1:0] r_prod;

  logic               w_accept;
  logic               w_step;
  logic               w_fix;
  logic               w_last;
  logic [WIDTH:0]     w_addend;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH-1:0]   w_x_mag;
  logic [WIDTH-1:0]   w_y_mag;
  logic               w_neg;
  logic               w_ovf;
  logic [2*WIDTH-1:0] w_prod;

  mult_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .i_sgn   (bus.sgn),
    .i_x     (bus.x),
    .i_y     (bus.y),
    .i_sgn_q (r_sgn),
    .i_neg_q (r_neg),
    .i_mag   (r_acc),
    .o_x_mag (w_x_mag),
    .o_y_mag (w_y_mag),
    .o_neg   (w_neg),
    .o_prod  (w_prod),
    .o_ovf   (w_ovf)
  );

  assign w_last = (r_cnt == CW'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // A start coinciding with the done pulse is refused so results are never overlapped.
  always_comb begin
    w_next   = IDLE;
    w_accept = 1'b0;
    w_step   = 1'b0;
    w_fix    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start && !r_done) begin
          w_accept = 1'b1;
          w_next   = CALC;
        end
      end
      CALC: begin
        w_step = 1'b1;
        w_next = w_last ? FIX : CALC;
      end
      FIX: begin
        w_fix  = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Upper half accumulates; lower half starts as the multiplier and shifts out.
  assign w_addend = r_acc[0] ? {1'b0, r_mcand} : '0;
  assign w_sum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + w_addend;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_mcand <= '0;
      r_acc   <= '0;
      r_sgn   <= 1'b0;
      r_neg   <= 1'b0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
      r_prod  <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_mcand <= w_x_mag;
        r_acc   <= {{WIDTH{1'b0}}, w_y_mag};
        r_sgn   <= bus.sgn;
        r_neg   <= w_neg;
        r_cnt   <= CW'(WIDTH);
      end else if (w_step) begin
        r_acc <= {w_sum, r_acc[WIDTH-1:1]};
        r_cnt <= r_cnt - CW'(1);
      end else if (w_fix) begin
        r_prod <= w_prod;
        r_ovf  <= w_ovf;
        r_done <= 1'b1;
      end
    end
  end

  assign bus.busy = (r_state == CALC) || (r_state == FIX);
  assign bus.done = r_done;
  assign bus.prod = r_prod;
  assign bus.res  = r_prod[WIDTH-1:0];
  assign bus.ovf  = r_ovf;

endmodule

// File: tb/tb_mult_seq_param.sv
// Directed bench for mult_seq_param at WIDTH=4, plus a full operand sweep.
module tb_mult_seq_param;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  mult_seq_param_if #(.WIDTH(4)) bus ();

  mult_seq_param #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issues one request from IDLE, scrambles the inputs after capture, and
  // checks busy, done timing (6th cycle after accept), results and pulse width.
  task automatic run(input string tag, input logic s, input logic [3:0] a,
                     input logic [3:0] b, input logic [7:0] ep, input logic eo);
    int n;
    bus.start = 1'b1;
    bus.sgn   = s;
    bus.x     = a;
    bus.y     = b;
    tick();
    bus.start = 1'b0;
    bus.sgn   = ~s;
    bus.x     = 4'($urandom);
    bus.y     = 4'($urandom);
    chk({tag, " busy"}, 64'(bus.busy), 64'(1));
    n = 1;
    while (bus.done !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, " latency"}, 64'(n), 64'(6));
    chk({tag, " prod"}, 64'(bus.prod), 64'(ep));
    chk({tag, " res"}, 64'(bus.res), 64'(ep[3:0]));
    chk({tag, " ovf"}, 64'(bus.ovf), 64'(eo));
    tick();
    chk({tag, " done_pulse"}, 64'(bus.done), 64'(0));
  endtask

  initial begin
    int n;
    int nd;
    logic [7:0] cap;
    int p;
    int sa;
    int sb;
    bus.start = 1'b0;
    bus.sgn   = 1'b0;
    bus.x     = '0;
    bus.y     = '0;

    // Reset state, with start held high during reset
    rst_n = 1'b0;
    bus.start = 1'b1;
    tick();
    tick();
    chk("rst busy", 64'(bus.busy), 64'(0));
    chk("rst done", 64'(bus.done), 64'(0));
    chk("rst prod", 64'(bus.prod), 64'(0));
    chk("rst ovf", 64'(bus.ovf), 64'(0));
    bus.start = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("start_in_rst ignored", 64'(bus.busy), 64'(0));

    run("u 3x5", 1'b0, 4'd3, 4'd5, 8'd15, 1'b0);
    run("u 15x15", 1'b0, 4'd15, 4'd15, 8'hE1, 1'b1);
    run("s -8x-1", 1'b1, 4'h8, 4'hF, 8'h08, 1'b1);
    run("s -2x3", 1'b1, 4'hE, 4'h3, 8'hFA, 1'b0);
    run("s -3x0", 1'b1, 4'hD, 4'h0, 8'h00, 1'b0);
    run("u 0x9", 1'b0, 4'h0, 4'h9, 8'h00, 1'b0);

    // Start mid-run is ignored: one done, original result
    bus.start = 1'b1; bus.sgn = 1'b0; bus.x = 4'd3; bus.y = 4'd5;
    tick();
    bus.start = 1'b0;
    tick();
    bus.start = 1'b1; bus.x = 4'd15; bus.y = 4'd15;
    tick();
    bus.start = 1'b0;
    nd = 0;
    cap = '0;
    for (int i = 0; i < 12; i++) begin
      if (bus.done === 1'b1) begin
        nd++;
        cap = bus.prod;
      end
      tick();
    end
    chk("midstart done_count", 64'(nd), 64'(1));
    chk("midstart prod", 64'(cap), 64'(15));

    // Reset in CALC aborts with no done
    bus.start = 1'b1; bus.x = 4'd7; bus.y = 4'd7;
    tick();
    bus.start = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort busy", 64'(bus.busy), 64'(0));
    chk("abort done", 64'(bus.done), 64'(0));
    chk("abort prod", 64'(bus.prod), 64'(0));
    chk("abort res", 64'(bus.res), 64'(0));
    chk("abort ovf", 64'(bus.ovf), 64'(0));
    nd = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.done === 1'b1) nd++;
      tick();
    end
    chk("abort no_done", 64'(nd), 64'(0));
    run("post_abort 7x7", 1'b0, 4'd7, 4'd7, 8'd49, 1'b1);

    // Start during the done cycle is refused
    bus.start = 1'b1; bus.sgn = 1'b0; bus.x = 4'd2; bus.y = 4'd3;
    tick();
    bus.start = 1'b0;
    n = 1;
    while (bus.done !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("donecyc latency", 64'(n), 64'(6));
    bus.start = 1'b1; bus.x = 4'd1; bus.y = 4'd1;
    tick();
    bus.start = 1'b0;
    chk("donecyc start refused", 64'(bus.busy), 64'(0));
    chk("donecyc prod held", 64'(bus.prod), 64'(6));
    tick();
    chk("donecyc still idle", 64'(bus.busy), 64'(0));
    run("after_done 5x5", 1'b0, 4'd5, 4'd5, 8'd25, 1'b1);

    // Full operand sweep against an integer reference product
    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          if (s == 0) begin
            p = a * b;
            run($sformatf("sw u x%0d y%0d", a, b), 1'b0, 4'(a), 4'(b), 8'(p), p > 15);
          end else begin
            sa = (a >= 8) ? a - 16 : a;
            sb = (b >= 8) ? b - 16 : b;
            p  = sa * sb;
            run($sformatf("sw s x%0d y%0d", sa, sb), 1'b1, 4'(a), 4'(b), 8'(p),
                (p > 7) || (p < -8));
          end
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
